// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift_reg2 command sequencer.
package shift_seq_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned OP_W_DEF  = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  // shift_reg2 opcodes: parallel load, and logical right shift by one with zero fill
  localparam logic [2:0] LOAD_OP = 3'b011;
  localparam logic [2:0] SHR_OP  = 3'b000;

endpackage

// File: rtl/shift_seq_cnt.sv
// Loadable shift-cycle down-counter; saturates at zero so it never wraps.
module shift_seq_cnt
  import shift_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving shift_reg2 pins: optional seed load, N shift cycles, capture, response.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned OP_W  = OP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_fill,
  output logic             sr_enable,
  output logic [OP_W-1:0]  sr_dir,
  output logic [WIDTH-1:0] sr_data_in,
  input  logic [WIDTH-1:0] sr_data_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] fill_q, fill_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             sr_enable_q, sr_enable_d;
  logic [OP_W-1:0]  sr_dir_q, sr_dir_d;
  logic [WIDTH-1:0] sr_data_in_q, sr_data_in_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  logic cnt_load, cnt_dec, cnt_zero, cnt_last;

  shift_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cmd_count),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero),
    .last_o     (cnt_last)
  );

  // Next state plus next values of the pin registers, which are decoded from state_d
  // so every output lines up with the state it belongs to.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    fill_d       = fill_q;
    rsp_data_d   = rsp_data_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    sr_data_in_d = '0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          fill_d   = cmd_fill;
          cnt_load = 1'b1;
          if (cmd_load) begin
            state_d = LOAD;
          end else if (cmd_count != '0) begin
            state_d = SHIFT;
          end else begin
            state_d = CAPT;
          end
        end
      end
      LOAD: begin
        state_d = cnt_zero ? CAPT : SHIFT;
      end
      SHIFT: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        rsp_data_d = sr_data_out;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
    sr_enable_d = (state_d == LOAD) || (state_d == SHIFT);
    sr_dir_d    = '0;
    if (state_d == LOAD) begin
      sr_dir_d     = OP_W'(LOAD_OP);
      sr_data_in_d = cmd_data;
    end else if (state_d == SHIFT) begin
      sr_dir_d     = op_d;
      sr_data_in_d = fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      fill_q       <= '0;
      rsp_data_q   <= '0;
      cmd_ready_q  <= 1'b1;
      sr_enable_q  <= 1'b0;
      sr_dir_q     <= '0;
      sr_data_in_q <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      fill_q       <= fill_d;
      rsp_data_q   <= rsp_data_d;
      cmd_ready_q  <= cmd_ready_d;
      sr_enable_q  <= sr_enable_d;
      sr_dir_q     <= sr_dir_d;
      sr_data_in_q <= sr_data_in_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign sr_enable  = sr_enable_q;
  assign sr_dir     = sr_dir_q;
  assign sr_data_in = sr_data_in_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl driving a behavioural shift_reg2 stand-in.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [7:0] cmd_data, cmd_fill;
  logic [2:0] cmd_op;
  logic [3:0] cmd_count;
  logic       sr_enable;
  logic [2:0] sr_dir;
  logic [7:0] sr_data_in, sr_data_out;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load    (cmd_load),
    .cmd_data    (cmd_data),
    .cmd_op      (cmd_op),
    .cmd_count   (cmd_count),
    .cmd_fill    (cmd_fill),
    .sr_enable   (sr_enable),
    .sr_dir      (sr_dir),
    .sr_data_in  (sr_data_in),
    .sr_data_out (sr_data_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  // shift_reg2 stand-in: 000 shr zero-fill, 001 shl zero-fill, 010 rotate right, 011 load
  logic [7:0] sr_q;
  always_ff @(posedge clk) begin
    if (sr_enable) begin
      case (sr_dir)
        3'b000:  sr_q <= {1'b0, sr_q[7:1]};
        3'b001:  sr_q <= {sr_q[6:0], 1'b0};
        3'b010:  sr_q <= {sr_q[0], sr_q[7:1]};
        3'b011:  sr_q <= sr_data_in;
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign sr_data_out = sr_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command in IDLE; returns in the first cycle after the accept edge.
  task automatic issue(input logic ld, input logic [7:0] data, input logic [2:0] op,
                       input logic [3:0] cnt, input logic [7:0] fill);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_data  = data;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_fill  = fill;
    step();
    cmd_valid = 1'b0;
  endtask

  // Full command: latency (cycle in which rsp_valid is first high), pin activity, result, handshake.
  task automatic run_cmd(input string tag, input logic ld, input logic [7:0] data,
                         input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] fill,
                         input logic [7:0] exp_data);
    int lat = 0;
    int en_cyc = 0;
    int load_cyc = 0;
    int shift_cyc = 0;
    issue(ld, data, op, cnt, fill);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd0);
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (rsp_valid) begin
        lat = c;
      end else begin
        if (sr_enable) begin
          en_cyc++;
          if (sr_dir == 3'b011 && sr_data_in == data) load_cyc++;
          else if (sr_dir == op && sr_data_in == fill) shift_cyc++;
        end
        step();
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(ld) + 32'(cnt) + 32'd2);
    chk({tag, " load_cycles"}, 32'(load_cyc), 32'(ld));
    chk({tag, " shift_cycles"}, 32'(shift_cyc), 32'(cnt));
    chk({tag, " enable_cycles"}, 32'(en_cyc), 32'(ld) + 32'(cnt));
    chk({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, " rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, " back_idle"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic saw_rsp;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_data  = '0;
    cmd_op    = '0;
    cmd_count = '0;
    cmd_fill  = '0;
    rsp_ready = 1'b1;
    step();
    step();
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst sr_enable", 32'(sr_enable), 32'd0);
    chk("rst sr_dir", 32'(sr_dir), 32'd0);
    chk("rst sr_data_in", 32'(sr_data_in), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_data", 32'(rsp_data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    reset = 1'b0;
    // rsp_ready high while idle must not disturb anything
    step();
    chk("idle rsp_ready busy", 32'(busy), 32'd0);
    rsp_ready = 1'b0;

    // 1: load only -> LOAD, CAPT, RESP
    run_cmd("s1", 1'b1, 8'hA5, 3'b000, 4'd0, 8'h00, 8'hA5);
    // 2: 0xA5 >> 3 = 0x14
    run_cmd("s2", 1'b1, 8'hA5, 3'b000, 4'd3, 8'h00, 8'h14);
    // 3: no load, 0x14 >> 1 = 0x0A
    run_cmd("s3", 1'b0, 8'h00, 3'b000, 4'd1, 8'h00, 8'h0A);
    // pure readback
    run_cmd("rdbk", 1'b0, 8'h00, 3'b000, 4'd0, 8'h00, 8'h0A);

    // 4: stalled response, 0x0A << 2 = 0x28; a cmd_valid pulse meanwhile is ignored
    issue(1'b0, 8'h00, 3'b001, 4'd2, 8'h00);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (rsp_valid) lat = c;
      else step();
    end
    chk("s4 latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("s4 hold rsp_valid", 32'(rsp_valid), 32'd1);
      chk("s4 hold rsp_data", 32'(rsp_data), 32'h28);
      chk("s4 hold cmd_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = (i == 3);
      cmd_load  = 1'b1;
      cmd_data  = 8'hFF;
      cmd_count = 4'd0;
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("s4 release rsp_valid", 32'(rsp_valid), 32'd0);
    chk("s4 release busy", 32'(busy), 32'd0);
    step();
    chk("s4 no ghost cmd", 32'(busy), 32'd0);

    // 5: reset during second SHIFT cycle of a count=7 command
    issue(1'b1, 8'h3C, 3'b000, 4'd7, 8'h00);
    step();
    step();
    chk("s5 in shift", 32'(sr_enable), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s5 sr_enable", 32'(sr_enable), 32'd0);
    chk("s5 busy", 32'(busy), 32'd0);
    chk("s5 cmd_ready", 32'(cmd_ready), 32'd1);
    chk("s5 sr_dir", 32'(sr_dir), 32'd0);
    chk("s5 sr_data_in", 32'(sr_data_in), 32'd0);
    saw_rsp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) saw_rsp = 1'b1;
      step();
    end
    chk("s5 no response", 32'(saw_rsp), 32'd0);

    // 6: count=15 rotate right of 0xA5 = rotate left by 1 = 0x4B
    run_cmd("s6", 1'b1, 8'hA5, 3'b010, 4'd15, 8'h5A, 8'h4B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command sequencer that sits directly upstream of shift_reg2 and drives its enable, shift_direction and data_in pins.
- Accepts one command at a time over a valid/ready handshake.
- Optionally parallel-loads a seed value, then applies a chosen shift_direction opcode for a programmed number of cycles.
- Samples shift_reg2.data_out and returns it over a valid/ready response channel.
- Lets a processor-side or stream-side master run multi-cycle shift operations without cycle-accurate pin control.

Parameters:
WIDTH, 8, data width of shift_reg2 (data_in/data_out)
CNT_W, 4, width of shift-count field; max shifts per command = 2**CNT_W-1
OP_W, 3, width of shift_direction opcode

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at rising edge
cmd_load  in  1  1: parallel-load cmd_data before shifting; 0: shift current register contents
cmd_data  in  WIDTH  seed value for load
cmd_op  in  OP_W  shift_direction opcode used during shift phase (opaque to this block)
cmd_count  in  CNT_W  number of shift cycles, 0..2**CNT_W-1
cmd_fill  in  WIDTH  value driven on sr_data_in during shift phase
sr_enable  out  1  to shift_reg2.enable
sr_dir  out  OP_W  to shift_reg2.shift_direction
sr_data_in  out  WIDTH  to shift_reg2.data_in
sr_data_out  in  WIDTH  from shift_reg2.data_out
rsp_valid  out  1  result available
rsp_ready  in  1  result consumed when rsp_valid&rsp_ready
rsp_data  out  WIDTH  captured register value
busy  out  1  high in any state but IDLE

Behaviour:
- All outputs are registered or decoded from state registers only; there is no combinational input-to-output path.
- States: IDLE, LOAD, SHIFT, CAPT, RESP.
- IDLE: cmd_ready=1, sr_enable=0. On accept, latch op/data/count/fill. Go to LOAD if cmd_load=1. Otherwise go to SHIFT if count!=0, else CAPT.
- LOAD (1 cycle): sr_enable=1, sr_dir=LOAD_OP (3'b011), sr_data_in=latched data. Next: SHIFT if count!=0, else CAPT.
- SHIFT: sr_enable=1, sr_dir=latched op, sr_data_in=latched fill. A down-counter is loaded with count and decrements each SHIFT cycle. Exit to CAPT after exactly count cycles.
- CAPT (1 cycle): sr_enable=0. rsp_data <= sr_data_out. This covers the shift_reg2 one-cycle update latency.
- RESP: rsp_valid=1 and rsp_data held stable until rsp_ready. Then go to IDLE.
- cmd_ready=0 outside IDLE. No back-to-back acceptance in RESP.
- Latency, accept edge to rsp_valid high: (cmd_load) + count + 2 cycles. Example: load, count=3 gives 6 cycles.
- Outside LOAD/SHIFT: sr_enable=0, sr_dir=0, sr_data_in=0.
- count=0 with cmd_load=0 is legal: pure readback, 2-cycle latency.
- cmd inputs are ignored while not in IDLE; changes do not affect an in-flight command.
- rsp_ready held high in IDLE has no effect.
- Reset (any state, including mid-SHIFT): next state IDLE. cmd_ready=1; sr_enable=0, sr_dir=0, sr_data_in=0; rsp_valid=0, rsp_data=0, busy=0; counter=0. The in-flight command is discarded without a response. shift_reg2 contents are not cleared by this block.

Decomposition:
- Package shift_seq_pkg: state enum (IDLE, LOAD, SHIFT, CAPT, RESP), LOAD_OP=3'b011, SHR_OP=3'b000 (logical shift right by 1, zero fill), default widths.
- The down-counter is the only natural sub-module: shift_seq_cnt (loadable, decrement, zero flag).
- Everything else stays in one FSM module.

Test Plan:
All scenarios run the DUT wired to a shift_reg2 instance.
1. reset, then cmd load=1 data=0xA5 count=0 -> sr_enable high exactly 1 cycle with sr_dir=011; rsp_valid 3 cycles after accept; rsp_data=0xA5.
2. cmd load=1 data=0xA5 op=000 count=3 -> 3 SHIFT cycles with sr_dir=000; rsp_data=0x14 at cycle 6.
3. cmd load=0 op=000 count=1 following scenario 2 -> rsp_data=0x0A; no LOAD cycle observed.
4. rsp_ready held low 10 cycles -> rsp_valid and rsp_data stable; cmd_ready=0; a cmd_valid pulse is ignored.
5. reset asserted on 2nd SHIFT cycle of a count=7 command -> next cycle sr_enable=0, busy=0, cmd_ready=1; no rsp_valid ever for that command.
6. cmd count=15 (max) -> exactly 15 consecutive sr_enable cycles after LOAD; counter does not wrap.
